// File: rtl/oled_boot_sequencer_if.sv
// ---------------------------------------------------------------------------
// oled_boot_sequencer_if
//   Bundles the signals of oled_boot_sequencer other than clock and reset:
//   - start control and busy/done status
//   - external table ROM port (seq_addr / seq_data)
//   - CPU request/grant and the CPU-side pin drives
//   - the physical SSD1306 pins
//   modport slave  : the sequencer itself
//   modport master : whoever drives start, the ROM data and the CPU pins
// ---------------------------------------------------------------------------
interface oled_boot_sequencer_if;
    logic       start;
    logic [7:0] seq_addr;
    logic [8:0] seq_data;
    logic       cpu_req;
    logic       cpu_gnt;
    logic       cpu_rst_n;
    logic       cpu_cs;
    logic       cpu_dc;
    logic       cpu_scl;
    logic       cpu_mosi;
    logic       oled_rst_n;
    logic       oled_cs;
    logic       oled_dc;
    logic       oled_scl;
    logic       oled_mosi;
    logic       busy;
    logic       done;

    modport slave (
        input  start, seq_data, cpu_req,
        input  cpu_rst_n, cpu_cs, cpu_dc, cpu_scl, cpu_mosi,
        output seq_addr, cpu_gnt, busy, done,
        output oled_rst_n, oled_cs, oled_dc, oled_scl, oled_mosi
    );

    modport master (
        output start, seq_data, cpu_req,
        output cpu_rst_n, cpu_cs, cpu_dc, cpu_scl, cpu_mosi,
        input  seq_addr, cpu_gnt, busy, done,
        input  oled_rst_n, oled_cs, oled_dc, oled_scl, oled_mosi
    );
endinterface

// File: rtl/oled_boot_sequencer.sv
// ---------------------------------------------------------------------------
// oled_boot_sequencer
//   Owns the SSD1306 pins. After start (or automatically out of reset) it
//   pulses the display reset, waits, then shifts a table of command/data
//   bytes out as SPI mode 0. When the table is exhausted it passes the pins
//   to the CPU, which gets them through a registered request/grant.
//
//   Ports
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : oled_boot_sequencer_if.slave
//              start, seq_addr/seq_data (combinational table ROM),
//              cpu_req/cpu_gnt, cpu_* pin drives, oled_* pins, busy, done
// ---------------------------------------------------------------------------
module oled_boot_sequencer #(
    parameter int    CLK_DIV         = 4,
    parameter int    RST_LOW_CYCLES  = 16,
    parameter int    RST_WAIT_CYCLES = 16,
    parameter int    SEQ_LEN         = 25,
    parameter string AUTO_START      = "TRUE"
) (
    input  logic                   clk,
    input  logic                   rst_n,
    oled_boot_sequencer_if.slave   bus
);

    localparam bit AUTO    = (AUTO_START == "TRUE");
    localparam int M1      = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
    localparam int CNT_MAX = (M1 > CLK_DIV) ? M1 : CLK_DIV;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RL_LAST  = CW'(RST_LOW_CYCLES - 1);
    localparam logic [CW-1:0] RW_LAST  = CW'(RST_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    // 9-bit index so SEQ_LEN=256 terminates at 255 without wrapping.
    localparam logic [8:0]    LAST_IDX = (SEQ_LEN == 0) ? 9'd0 : 9'(SEQ_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, RST_LOW, RST_WAIT, LOAD, CS_SETUP, SHIFT, GAP, PASS
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    bit_q,   bit_d;
    logic          scl_q,   scl_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          dc_q,    dc_d;
    logic [8:0]    idx_q,   idx_d;
    logic          gnt_q,   gnt_d;
    logic          done_q,  done_d;
    logic          pend_q,  pend_d;
    logic          first_q, first_d;

    logic          hold_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            scl_q   <= 1'b0;
            shreg_q <= '0;
            dc_q    <= 1'b0;
            idx_q   <= '0;
            gnt_q   <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            scl_q   <= scl_d;
            shreg_q <= shreg_d;
            dc_q    <= dc_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            first_q <= first_d;
        end
    end

    // A restart in PASS must not cut a CPU transfer short: while the CPU
    // holds the bus with CS asserted, the request is parked in pend_q.
    assign hold_off = gnt_q && !bus.cpu_cs;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        scl_d   = scl_q;
        shreg_d = shreg_q;
        dc_d    = dc_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        pend_d  = pend_q;
        first_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start || (AUTO && first_q)) begin
                    state_d = RST_LOW;
                    cnt_d   = '0;
                end
            end
            RST_LOW: begin
                if (cnt_q == RL_LAST) begin
                    state_d = RST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RST_WAIT: begin
                if (cnt_q == RW_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (SEQ_LEN == 0) begin
                        state_d = PASS;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOAD: begin
                shreg_d = bus.seq_data[7:0];
                dc_d    = bus.seq_data[8];
                state_d = CS_SETUP;
                cnt_d   = '0;
            end
            CS_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    scl_d   = 1'b0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!scl_q) begin
                        scl_d = 1'b1;
                    end else begin
                        // Falling SCL edge: the only place MOSI may advance.
                        scl_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            state_d = GAP;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shreg_d = {shreg_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = PASS;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 9'd1;
                        state_d = LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PASS: begin
                gnt_d = bus.cpu_req;
                if (bus.start && hold_off) begin
                    pend_d = 1'b1;
                end
                if ((bus.start || pend_q) && !hold_off) begin
                    state_d = RST_LOW;
                    cnt_d   = '0;
                    idx_d   = '0;
                    gnt_d   = 1'b0;
                    done_d  = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer-driven pin levels, ordered {rst_n, cs, dc, scl, mosi}.
    logic       spi_active;
    logic [4:0] seq_pins;
    logic [4:0] cpu_pins;
    logic [4:0] pins;

    assign spi_active = (state_q == CS_SETUP) || (state_q == SHIFT);
    assign seq_pins = {
        !((state_q == IDLE) || (state_q == RST_LOW)),
        !spi_active,
        spi_active & dc_q,
        (state_q == SHIFT) & scl_q,
        spi_active & shreg_q[7]
    };
    assign cpu_pins = {bus.cpu_rst_n, bus.cpu_cs, bus.cpu_dc, bus.cpu_scl, bus.cpu_mosi};

    // gnt_q can only be set in PASS and is cleared on leaving it, so the
    // mux is purely combinational with no added latency on the CPU path.
    for (genvar gi = 0; gi < 5; gi++) begin : g_pin_mux
        assign pins[gi] = gnt_q ? cpu_pins[gi] : seq_pins[gi];
    end

    assign bus.oled_rst_n = pins[4];
    assign bus.oled_cs    = pins[3];
    assign bus.oled_dc    = pins[2];
    assign bus.oled_scl   = pins[1];
    assign bus.oled_mosi  = pins[0];

    assign bus.seq_addr = idx_q[7:0];
    assign bus.cpu_gnt  = gnt_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != IDLE) && (state_q != PASS);

endmodule
